// File: rtl/peak_hold_release.sv
// -----------------------------------------------------------------------------
// peak_hold_release
//
// Tracks the running maximum of a sample stream. The peak is held for
// hold_cycles clocks and then decays by one LSB every decay_interval clocks.
// Decay stops at the floor, which is the most recent valid sample. Meters and
// threshold logic downstream use it so that old peaks fade away.
//
// Parameters
//   data_width      sample / peak width in bits (>= 1)
//   hold_cycles     clocks a freshly captured peak is held (>= 1)
//   decay_interval  clocks between successive 1-LSB decay steps (>= 1)
//
// Ports
//   clock     in   rising-edge clock (only clock used)
//   reset     in   asynchronous, active-low reset
//   valid     in   data carries a sample this cycle
//   data      in   unsigned input sample
//   peak      out  registered peak value
//   holding   out  registered, high while in HOLD
//   decaying  out  registered, high while in DECAY
// -----------------------------------------------------------------------------
module peak_hold_release #(
    parameter int data_width     = 8,
    parameter int hold_cycles    = 4,
    parameter int decay_interval = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid,
    input  logic [data_width-1:0] data,
    output logic [data_width-1:0] peak,
    output logic                  holding,
    output logic                  decaying
);

    // Counter widths never shrink below one bit. This keeps the degenerate
    // hold_cycles == 1 and decay_interval == 1 cases legal.
    localparam int HCW = (hold_cycles    > 1) ? $clog2(hold_cycles)    : 1;
    localparam int SCW = (decay_interval > 1) ? $clog2(decay_interval) : 1;

    localparam logic [HCW-1:0] HOLD_RELOAD = HCW'(hold_cycles - 1);
    localparam logic [SCW-1:0] STEP_RELOAD = SCW'(decay_interval - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } state_t;

    state_t                state_reg,    state_next;
    logic [data_width-1:0] peak_reg,     peak_next;
    logic [data_width-1:0] last_reg,     last_next;
    logic [HCW-1:0]        hold_cnt_reg, hold_cnt_next;
    logic [SCW-1:0]        step_cnt_reg, step_cnt_next;
    logic                  holding_reg,  holding_next;
    logic                  decaying_reg, decaying_next;

    logic                  capture;
    logic [data_width:0]   peak_ext;
    logic [data_width:0]   floor_plus_one;
    logic                  above_floor;

    // The floor is the value last takes after this edge. A valid sample that
    // arrives on a decay-step edge therefore limits that step.
    assign last_next = valid ? data : last_reg;

    // An equal sample also counts as a capture, so it restarts the hold.
    assign capture = valid && (data >= peak_reg);

    // "peak - 1 > floor" is rewritten as "peak > floor + 1". One extra bit
    // keeps both sides free of wrap-around at the all-zeros and all-ones ends.
    assign peak_ext       = {1'b0, peak_reg};
    assign floor_plus_one = {1'b0, last_next} + {{data_width{1'b0}}, 1'b1};
    assign above_floor    = (peak_ext > floor_plus_one);

    always_comb begin
        state_next    = state_reg;
        peak_next     = peak_reg;
        hold_cnt_next = hold_cnt_reg;
        step_cnt_next = step_cnt_reg;

        if (capture) begin
            // Capture wins over hold expiry and decay steps in every state.
            peak_next     = data;
            state_next    = HOLD;
            hold_cnt_next = HOLD_RELOAD;
        end else begin
            case (state_reg)
                IDLE: begin
                    // A lower sample means the current peak is stale. It was
                    // already held earlier, so it goes straight to decay.
                    if (valid) begin
                        state_next    = DECAY;
                        step_cnt_next = STEP_RELOAD;
                    end
                end

                HOLD: begin
                    if (hold_cnt_reg == '0) begin
                        state_next    = DECAY;
                        step_cnt_next = STEP_RELOAD;
                    end else begin
                        hold_cnt_next = hold_cnt_reg - HCW'(1);
                    end
                end

                DECAY: begin
                    if (step_cnt_reg != '0) begin
                        step_cnt_next = step_cnt_reg - SCW'(1);
                    end else begin
                        step_cnt_next = STEP_RELOAD;
                        if (above_floor) begin
                            peak_next = peak_reg - data_width'(1);
                        end else begin
                            // Clamp to the floor and stop decaying.
                            peak_next  = last_next;
                            state_next = IDLE;
                        end
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // The status flags are decoded from the next state and then registered,
    // so the outputs come straight from flops with no input-to-output path.
    always_comb begin
        holding_next  = (state_next == HOLD);
        decaying_next = (state_next == DECAY);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            peak_reg     <= '0;
            last_reg     <= '0;
            hold_cnt_reg <= '0;
            step_cnt_reg <= '0;
            holding_reg  <= 1'b0;
            decaying_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            peak_reg     <= peak_next;
            last_reg     <= last_next;
            hold_cnt_reg <= hold_cnt_next;
            step_cnt_reg <= step_cnt_next;
            holding_reg  <= holding_next;
            decaying_reg <= decaying_next;
        end
    end

    assign peak     = peak_reg;
    assign holding  = holding_reg;
    assign decaying = decaying_reg;

endmodule

// File: tb/tb_peak_hold_release.sv
// -----------------------------------------------------------------------------
// tb_peak_hold_release
//
// Self-checking bench for peak_hold_release.
//   u_a : data_width=8, hold_cycles=4, decay_interval=2 (table + sequences)
//   u_b : data_width=8, hold_cycles=1, decay_interval=1 (extreme sequence)
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled
// 1 time unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_peak_hold_release;

    logic       clock;
    logic       reset;
    logic       a_valid;
    logic [7:0] a_data;
    logic [7:0] a_peak;
    logic       a_holding;
    logic       a_decaying;
    logic       b_valid;
    logic [7:0] b_data;
    logic [7:0] b_peak;
    logic       b_holding;
    logic       b_decaying;

    int n_cmp = 0;
    int n_err = 0;

    peak_hold_release #(
        .data_width(8), .hold_cycles(4), .decay_interval(2)
    ) u_a (
        .clock(clock), .reset(reset), .valid(a_valid), .data(a_data),
        .peak(a_peak), .holding(a_holding), .decaying(a_decaying)
    );

    peak_hold_release #(
        .data_width(8), .hold_cycles(1), .decay_interval(1)
    ) u_b (
        .clock(clock), .reset(reset), .valid(b_valid), .data(b_data),
        .peak(b_peak), .holding(b_holding), .decaying(b_decaying)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [7:0] p;
        logic       h;
        logic       dc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic v, input logic [7:0] d,
                                input logic [7:0] p, input logic h,
                                input logic dc);
        vec_t r;
        r.v = v; r.d = d; r.p = p; r.h = h; r.dc = dc;
        tbl.push_back(r);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [7:0] p,
                           input logic h, input logic dc);
        check({tag, " peak"},     a_peak,     p);
        check({tag, " holding"},  a_holding,  h);
        check({tag, " decaying"}, a_decaying, dc);
        $display("%s: peak=%0d holding=%0d decaying=%0d", tag, a_peak, a_holding, a_decaying);
    endtask

    task automatic clk_a(input logic v, input logic [7:0] d);
        a_valid = v;
        a_data  = d;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        a_valid = 1'b0; a_data = 8'd0;
        b_valid = 1'b0; b_data = 8'd0;

        // Reset held for 3 clocks.
        repeat (3) @(posedge clock);
        #1;
        check_a("reset", 8'd0, 1'b0, 1'b0);
        check("reset b_peak", b_peak, 0);
        @(negedge clock);
        reset = 1'b1;

        // ---------------- table (u_a: hold 4, interval 2) ----------------
        // Basic hold/decay: 10 then 6, decay 10 -> 6.
        add(1, 10, 10, 1, 0);   // edge 0 capture
        add(1,  6, 10, 1, 0);   // edge 1 floor=6
        add(0,  0, 10, 1, 0);
        add(0,  0, 10, 1, 0);   // edge 3 last held clock
        add(0,  0, 10, 0, 1);   // edge 4 enter DECAY
        add(0,  0, 10, 0, 1);
        add(0,  0,  9, 0, 1);   // edge 6
        add(0,  0,  9, 0, 1);
        add(0,  0,  8, 0, 1);   // edge 8
        add(0,  0,  8, 0, 1);
        add(0,  0,  7, 0, 1);   // edge 10
        add(0,  0,  7, 0, 1);
        add(0,  0,  6, 0, 0);   // edge 12 clamp to floor, IDLE
        // Lower sample in IDLE: direct DECAY, 5,4,3 then IDLE.
        add(1,  3,  6, 0, 1);
        add(0,  0,  6, 0, 1);
        add(0,  0,  5, 0, 1);
        add(0,  0,  5, 0, 1);
        add(0,  0,  4, 0, 1);
        add(0,  0,  4, 0, 1);
        add(0,  0,  3, 0, 0);
        // Build up to DECAY at peak 8 with floor 2.
        add(1, 12, 12, 1, 0);
        add(1,  2, 12, 1, 0);
        add(0,  0, 12, 1, 0);
        add(0,  0, 12, 1, 0);
        add(0,  0, 12, 0, 1);
        add(0,  0, 12, 0, 1);
        add(0,  0, 11, 0, 1);
        add(0,  0, 11, 0, 1);
        add(0,  0, 10, 0, 1);
        add(0,  0, 10, 0, 1);
        add(0,  0,  9, 0, 1);
        add(0,  0,  9, 0, 1);
        add(0,  0,  8, 0, 1);
        add(0,  0,  8, 0, 1);
        // Recapture during DECAY: a full 4-clock hold follows.
        add(1, 20, 20, 1, 0);
        add(0,  0, 20, 1, 0);
        add(0,  0, 20, 1, 0);
        add(0,  0, 20, 1, 0);
        add(0,  0, 20, 0, 1);
        add(0,  0, 20, 0, 1);
        // Floor equals peak, so the first step clamps and returns to IDLE.
        add(0,  0, 20, 0, 0);
        // Extremes: all-ones captures, then the floor drops to 0.
        add(1, 255, 255, 1, 0);
        add(1,   0, 255, 1, 0);
        add(0,   0, 255, 1, 0);
        add(0,   0, 255, 1, 0);
        add(0,   0, 255, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            clk_a(tbl[i].v, tbl[i].d);
            check_a($sformatf("row%0d", i), tbl[i].p, tbl[i].h, tbl[i].dc);
        end

        // Decay 255 -> 0: one step every 2 clocks, ending in IDLE, no underflow.
        for (int j = 1; j <= 511; j++) begin
            clk_a(0, 0);
            check($sformatf("u_a decay j=%0d peak", j), a_peak,
                  (j >= 510) ? 0 : 255 - j / 2);
            check($sformatf("u_a decay j=%0d decaying", j), a_decaying,
                  (j < 510) ? 1 : 0);
        end
        $display("u_a extreme decay done: peak=%0d decaying=%0d", a_peak, a_decaying);

        // ---------------- async reset mid-DECAY ----------------
        clk_a(1, 50);
        clk_a(1, 1);
        clk_a(0, 0);
        clk_a(0, 0);
        clk_a(0, 0);
        clk_a(0, 0);
        check_a("pre-reset", 8'd50, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1;                     // no clock edge since reset fell
        check_a("async reset", 8'd0, 1'b0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // ---------------- equal sample restarts hold ----------------
        clk_a(1, 10);
        check_a("eq e0", 8'd10, 1'b1, 1'b0);
        clk_a(0, 0);
        check_a("eq e1", 8'd10, 1'b1, 1'b0);
        clk_a(1, 10);           // equal sample on the 3rd held clock
        check_a("eq e2", 8'd10, 1'b1, 1'b0);
        clk_a(0, 0);
        check_a("eq e3", 8'd10, 1'b1, 1'b0);
        clk_a(0, 0);
        check_a("eq e4", 8'd10, 1'b1, 1'b0);
        clk_a(0, 0);
        check_a("eq e5", 8'd10, 1'b1, 1'b0);
        clk_a(0, 0);
        check_a("eq e6", 8'd10, 1'b0, 1'b1);

        // ---------------- u_b: hold 1, interval 1 ----------------
        b_valid = 1'b1; b_data = 8'd255;
        @(posedge clock); #1;
        check("u_b cap peak", b_peak, 255);
        check("u_b cap holding", b_holding, 1);
        check("u_b cap decaying", b_decaying, 0);
        $display("u_b cap: peak=%0d holding=%0d decaying=%0d", b_peak, b_holding, b_decaying);
        b_valid = 1'b1; b_data = 8'd0;
        @(posedge clock); #1;
        check("u_b e1 peak", b_peak, 255);
        check("u_b e1 holding", b_holding, 0);
        check("u_b e1 decaying", b_decaying, 1);
        $display("u_b e1: peak=%0d holding=%0d decaying=%0d", b_peak, b_holding, b_decaying);
        b_valid = 1'b0;
        for (int j = 1; j <= 256; j++) begin
            @(posedge clock); #1;
            check($sformatf("u_b decay j=%0d peak", j), b_peak,
                  (j >= 255) ? 0 : 255 - j);
            check($sformatf("u_b decay j=%0d decaying", j), b_decaying,
                  (j < 255) ? 1 : 0);
            check($sformatf("u_b decay j=%0d holding", j), b_holding, 0);
        end
        $display("u_b extreme decay done: peak=%0d decaying=%0d", b_peak, b_decaying);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
